// File: rtl/result_stream_tx.sv
// Snapshots NUM_CH result words and streams them as NIB_W-bit symbols with a
// stretched strobe. Channel 0 goes first, and each channel is sent least-significant symbol first.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// S_IDLE   | waiting for start; results are captured on any clk with start=1
// S_ARM    | snapshot held, waiting for the first tick to present symbol 0
// S_STROBE | strobe high, down-counting STROBE_TICKS ticks
// S_GAP    | strobe low, down-counting GAP_TICKS ticks, then next symbol / frame end
module result_stream_tx #(
  parameter int NUM_CH       = 3,
  parameter int RES_W        = 16,
  parameter int NIB_W        = 4,
  parameter int STROBE_TICKS = 3,
  parameter int GAP_TICKS    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    start,
  input  logic [NUM_CH*RES_W-1:0] results,
  input  logic                    repeat_mode,
  output logic [NIB_W-1:0]        data_out,
  output logic                    strobe,
  output logic                    frame_start,
  output logic                    busy,
  output logic                    done
);

  localparam int NPC   = (RES_W + NIB_W - 1) / NIB_W;
  localparam int SYMS  = NUM_CH * NPC;
  localparam int SH_W  = SYMS * NIB_W;
  localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int S_W   = (STROBE_TICKS > 1) ? $clog2(STROBE_TICKS) : 1;
  localparam int G_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TMR_W = (S_W > G_W) ? S_W : G_W;

  localparam logic [TMR_W-1:0] STR_LOAD = TMR_W'(STROBE_TICKS - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STROBE, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    shadow_q, shadow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NIB_W-1:0]   data_q, data_d;
  logic               strobe_q, strobe_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SH_W-1:0]    padded;
  logic [IDX_W-1:0]   idx_inc;

  // Each channel occupies NPC whole symbols; unused top bits stay zero.
  always_comb begin
    padded = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      padded[c*NPC*NIB_W +: RES_W] = results[c*RES_W +: RES_W];
    end
  end

  assign idx_inc = idx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    fs_d     = fs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = padded;
          busy_d   = 1'b1;
          idx_d    = '0;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        if (tick) begin
          data_d   = shadow_q[NIB_W-1:0];
          strobe_d = 1'b1;
          fs_d     = 1'b1;
          tmr_d    = STR_LOAD;
          state_d  = S_STROBE;
        end
      end

      S_STROBE: begin
        if (tick) begin
          if (tmr_q == '0) begin
            strobe_d = 1'b0;
            fs_d     = 1'b0;
            tmr_d    = GAP_LOAD;
            state_d  = S_GAP;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
          end else if (idx_q != LAST_IDX) begin
            idx_d    = idx_inc;
            data_d   = shadow_q[idx_inc*NIB_W +: NIB_W];
            strobe_d = 1'b1;
            tmr_d    = STR_LOAD;
            state_d  = S_STROBE;
          end else if (repeat_mode) begin
            // Fresh snapshot goes straight out, so the symbol period is unbroken.
            shadow_d = padded;
            idx_d    = '0;
            data_d   = padded[NIB_W-1:0];
            strobe_d = 1'b1;
            fs_d     = 1'b1;
            tmr_d    = STR_LOAD;
            state_d  = S_STROBE;
          end else begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out    = data_q;
  assign strobe      = strobe_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_result_stream_tx.sv
// Directed bench for result_stream_tx: table-driven one-shot frames on the default
// build plus hand sequences for repeat, ignored start, reset abort, held start and a padded build.
module tb_result_stream_tx;

  logic        clk = 1'b0;
  logic        reset_n, tick, start, repeat_mode, sel;
  logic [47:0] results1;
  logic [19:0] results2;
  logic        start1, start2;

  logic [3:0]  d1, d2;
  logic        st1, fs1, b1, dn1, st2, fs2, b2, dn2;
  logic [3:0]  m_data;
  logic        m_strobe, m_fs, m_busy, m_done;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  result_stream_tx u_dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start1), .results(results1),
    .repeat_mode(repeat_mode), .data_out(d1), .strobe(st1), .frame_start(fs1),
    .busy(b1), .done(dn1));

  result_stream_tx #(.NUM_CH(2), .RES_W(10), .NIB_W(4), .STROBE_TICKS(1), .GAP_TICKS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start2), .results(results2),
    .repeat_mode(repeat_mode), .data_out(d2), .strobe(st2), .frame_start(fs2),
    .busy(b2), .done(dn2));

  assign m_data   = sel ? d2  : d1;
  assign m_strobe = sel ? st2 : st1;
  assign m_fs     = sel ? fs2 : fs1;
  assign m_busy   = sel ? b2  : b1;
  assign m_done   = sel ? dn2 : dn1;

  int checks = 0;
  int errors = 0;

  int         cyc;
  logic       prev_st, prev_b;
  logic [3:0] prev_d;
  logic [3:0] q_sym[$];
  logic       q_fs[$];
  int         q_rise[$];
  int         q_hi[$];
  int         done_cnt, dchg_bad, fs_bad, busy_bad;
  bit         tick_en, force_tick;
  int         inj_at, rep_off_at;
  logic [47:0] inj_res;
  bit         inj_start, inj_fired, inj_pulse;

  typedef struct {
    logic [47:0] res;
    logic [47:0] exp;   // transmission order, first symbol in the top nibble
    string       name;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    q_sym.delete(); q_fs.delete(); q_rise.delete(); q_hi.delete();
    done_cnt = 0; dchg_bad = 0; fs_bad = 0; busy_bad = 0;
    prev_st = m_strobe; prev_d = m_data; prev_b = m_busy;
    inj_at = -1; rep_off_at = -1; inj_fired = 0; inj_start = 0;
  endtask

  task automatic step();
    bit rise;
    @(negedge clk);
    cyc++;
    if (inj_pulse) begin start = 0; inj_pulse = 0; end
    rise = m_strobe && !prev_st;
    if (rise) begin
      q_sym.push_back(m_data); q_fs.push_back(m_fs); q_rise.push_back(cyc);
    end
    if (!m_strobe && prev_st && q_rise.size() > 0) q_hi.push_back(cyc - q_rise[$]);
    if (m_data !== prev_d && !rise) dchg_bad++;
    if (m_fs && !m_strobe) fs_bad++;
    if (m_done) begin done_cnt++; if (m_busy) busy_bad++; end
    if (prev_b && !m_busy && !m_done) busy_bad++;
    prev_st = m_strobe; prev_d = m_data; prev_b = m_busy;
    if (inj_at >= 0 && !inj_fired && q_sym.size() >= inj_at) begin
      results1 = inj_res;
      if (inj_start) begin start = 1; inj_pulse = 1; end
      inj_fired = 1;
    end
    if (rep_off_at >= 0 && q_sym.size() >= rep_off_at) repeat_mode = 0;
    tick = force_tick || (tick_en && (cyc % 4 == 0));
    force_tick = 0;
  endtask

  task automatic run(input int budget, input int trail);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    repeat (trail) step();
  endtask

  task automatic check_frame(input string tag, input int nsym, input int flen,
                             input logic [95:0] exp, input int hi, input int per);
    int hi_bad = 0;
    int per_bad = 0;
    chk({tag, "_nsym"}, q_sym.size(), nsym);
    for (int i = 0; i < nsym && i < q_sym.size(); i++) begin
      chk($sformatf("%s_sym%0d", tag, i), q_sym[i], exp[95-4*i -: 4]);
      chk($sformatf("%s_fs%0d", tag, i), q_fs[i], (i % flen == 0));
    end
    foreach (q_hi[i]) if (q_hi[i] != hi) hi_bad++;
    for (int i = 1; i < q_rise.size(); i++) if (q_rise[i] - q_rise[i-1] != per) per_bad++;
    chk({tag, "_strobe_width"}, hi_bad, 0);
    chk({tag, "_period"}, per_bad, 0);
    chk({tag, "_data_stable"}, dchg_bad, 0);
    chk({tag, "_fs_without_strobe"}, fs_bad, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    vecs[0] = '{res: {16'd5, 16'd3, 16'd6},           exp: 48'h6000_3000_5000, name: "v536"};
    vecs[1] = '{res: {16'h0, 16'h0, 16'hA5C3},        exp: 48'h3C5A_0000_0000, name: "vA5C3"};
    vecs[2] = '{res: {16'h0F0F, 16'hBEEF, 16'h1234},  exp: 48'h4321_FEEB_F0F0, name: "vmix"};
    vecs[3] = '{res: {16'hFFFF, 16'hFFFF, 16'hFFFF},  exp: 48'hFFFF_FFFF_FFFF, name: "vones"};

    reset_n = 0; tick = 0; start = 0; repeat_mode = 0; sel = 0;
    results1 = '0; results2 = '0; cyc = 0; tick_en = 1; force_tick = 0; inj_pulse = 0;
    inj_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", d1, 0);
    chk("rst_strobe", st1, 0);
    chk("rst_fs", fs1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_done", dn1, 0);
    chk("rst_busy2", b2, 0);
    reset_n = 1;
    clr();
    step();

    foreach (vecs[v]) begin
      results1 = vecs[v].res;
      clr();
      start = 1; step(); start = 0;
      run(600, 4);
      check_frame(vecs[v].name, 12, 12, {vecs[v].exp, 48'h0}, 12, 16);
    end

    // start pulsed while symbol 5 is out, with different results on the bus
    results1 = {16'd5, 16'd3, 16'd6};
    clr();
    inj_at = 6; inj_res = 48'hFFFF_FFFF_FFFF; inj_start = 1;
    start = 1; step(); start = 0;
    run(600, 4);
    check_frame("ign", 12, 12, {48'h6000_3000_5000, 48'h0}, 12, 16);

    // repeat mode: mid-frame change shows up only in the next frame
    results1 = {16'd5, 16'd3, 16'd6};
    repeat_mode = 1;
    clr();
    inj_at = 4; inj_res = {32'h0, 16'h7}; inj_start = 0; rep_off_at = 14;
    start = 1; step(); start = 0;
    run(1200, 4);
    check_frame("rep", 24, 12, {48'h6000_3000_5000, 48'h7000_0000_0000}, 12, 16);

    // reset during the strobe of symbol 4
    results1 = {16'd5, 16'd3, 16'd6};
    clr();
    start = 1; step(); start = 0;
    for (int n = 0; n < 400 && q_sym.size() < 5; n++) step();
    chk("rst_mid_reached", q_sym.size(), 5);
    repeat (3) step();
    chk("rst_mid_pre_strobe", st1, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_data", d1, 0);
    chk("rst_mid_strobe", st1, 0);
    chk("rst_mid_fs", fs1, 0);
    chk("rst_mid_busy", b1, 0);
    chk("rst_mid_done", dn1, 0);
    @(negedge clk);
    reset_n = 1;
    clr();
    repeat (40) step();
    chk("rst_mid_nosym", q_sym.size(), 0);
    chk("rst_mid_idle_busy", m_busy, 0);
    chk("rst_mid_nodone", done_cnt, 0);

    // start and tick on the same clk, then no ticks for a while
    tick_en = 0;
    clr();
    start = 1; tick = 1; step(); start = 0;
    repeat (20) step();
    chk("tick0_busy", m_busy, 1);
    chk("tick0_strobe", m_strobe, 0);
    chk("tick0_data", m_data, 0);
    chk("tick0_nosym", q_sym.size(), 0);
    tick_en = 1;
    run(600, 4);
    check_frame("tick0", 12, 12, {48'h6000_3000_5000, 48'h0}, 12, 16);

    // start held: a new frame is captured on the clk after done
    results1 = {16'h0F0F, 16'hBEEF, 16'h1234};
    clr();
    start = 1;
    run(600, 0);
    check_frame("held1", 12, 12, {48'h4321_FEEB_F0F0, 48'h0}, 12, 16);
    step();
    chk("held_rebusy", m_busy, 1);
    start = 0;
    clr();
    run(600, 4);
    check_frame("held2", 12, 12, {48'h4321_FEEB_F0F0, 48'h0}, 12, 16);

    // 10-bit results on 4-bit symbols: top symbol zero-padded
    sel = 1;
    results2 = {10'h155, 10'h3FF};
    clr();
    start = 1; step(); start = 0;
    run(600, 4);
    check_frame("pad", 6, 6, {24'hFF3551, 72'h0}, 4, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
